// File: rtl/hwpe_stream_addressgen_sched.sv
// Round-robin job scheduler that time-shares one address generator between NB_REQ requesters.
// Each accepted job is sequenced through generator clear, presample and run, then acknowledged with a done pulse.
module hwpe_stream_addressgen_sched #(
    parameter int unsigned NB_REQ    = 2,
    parameter int unsigned ID_W      = (NB_REQ > 1) ? $clog2(NB_REQ) : 1,
    parameter int unsigned JOB_CNT_W = 16,
    parameter type ctrl_addressgen_v3_t = logic [63:0]
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [NB_REQ-1:0]    req_valid_i,
    output logic [NB_REQ-1:0]    req_ready_o,
    input  ctrl_addressgen_v3_t  req_ctrl_i [NB_REQ],
    output logic [NB_REQ-1:0]    req_done_o,
    output ctrl_addressgen_v3_t  ag_ctrl_o,
    output logic                 ag_clear_o,
    output logic                 ag_presample_o,
    output logic                 ag_enable_o,
    input  logic                 ag_done_i,
    output logic                 busy_o,
    output logic [ID_W-1:0]      grant_id_o,
    output logic [JOB_CNT_W-1:0] jobs_done_o
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        RUN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     lo_idx, hi_idx;
    logic                lo_found, hi_found;
    logic                any_valid;
    logic                accept;
    logic                clear_q;
    logic [JOB_CNT_W-1:0] jobs_q;
    logic [ID_W-1:0]     grant_q;
    ctrl_addressgen_v3_t ctrl_q;

    // Two-pass search: first valid at/after the pointer, else first valid from index 0 (wrap).
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            if (req_valid_i[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
            end
            if (req_valid_i[i] && (ID_W'(i) >= rr_ptr_q) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = ID_W'(i);
            end
        end
        any_valid = lo_found;
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    assign accept = (state_q == IDLE) && any_valid && !clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clear_q <= clear_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_valid) state_d = CLEAR;
            CLEAR:   state_d = START;
            START:   state_d = RUN;
            RUN:     if (ag_done_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    always_comb begin
        ag_clear_o     = (state_q == CLEAR) || clear_q;
        ag_presample_o = (state_q == START);
        ag_enable_o    = (state_q == RUN);
        busy_o         = (state_q != IDLE);
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            req_ready_o[i] = accept && (grant_idx == ID_W'(i));
            req_done_o[i]  = (state_q == DONE) && !clear_i && (grant_q == ID_W'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            grant_q  <= '0;
            ctrl_q   <= '0;
            jobs_q   <= '0;
        end else begin
            if (accept) begin
                grant_q  <= grant_idx;
                ctrl_q   <= req_ctrl_i[grant_idx];
                rr_ptr_q <= (grant_idx == ID_W'(NB_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
            if ((state_q == DONE) && !clear_i) begin
                jobs_q <= jobs_q + JOB_CNT_W'(1);
            end
        end
    end

    assign ag_ctrl_o   = ctrl_q;
    assign grant_id_o  = grant_q;
    assign jobs_done_o = jobs_q;

endmodule
